// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Produces packed BCD digits, leading-zero blank flags and an overflow flag for the HEX displays.
module bin2bcd_seq #(
   parameter int W      = 20,
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_in,
   input  logic [W-1:0]          bin_in,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     blank_out,
   output logic                  ovf_out
);

   localparam int BW   = 4 * DIGITS;
   localparam int CW   = $clog2(W + 1);
   localparam int CMPW = ((W > BW) ? W : BW) + 1;

   // Largest value representable in DIGITS decimal digits, evaluated at elaboration.
   function automatic logic [CMPW-1:0] max_decimal();
      logic [CMPW-1:0] v;
      v = {{(CMPW-1){1'b0}}, 1'b1};
      for (int i = 0; i < DIGITS; i++) begin
         v = v * CMPW'(10);
      end
      return v - {{(CMPW-1){1'b0}}, 1'b1};
   endfunction

   localparam logic [CMPW-1:0] MAX_VAL = max_decimal();

   function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] acc);
      logic [BW-1:0] r;
      logic [3:0]    nib;
      r = acc;
      for (int i = 0; i < DIGITS; i++) begin
         nib = acc[4*i +: 4];
         if (nib >= 4'd5) begin
            r[4*i +: 4] = nib + 4'd3;
         end else begin
            r[4*i +: 4] = nib;
         end
      end
      return r;
   endfunction

   // Digit i is blanked when it and every more significant digit are zero; digit 0 never is.
   function automatic logic [DIGITS-1:0] leading_blank(input logic [BW-1:0] acc);
      logic [DIGITS-1:0] b;
      logic              zero_above;
      b          = {DIGITS{1'b0}};
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_above = zero_above & (acc[4*i +: 4] == 4'd0);
         b[i]       = zero_above;
      end
      return b;
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_r;
   logic [W-1:0]        bin_r;
   logic [BW-1:0]       acc_r;
   logic [CW-1:0]       cnt_r;
   logic                ovf_pend_r;
   logic                busy_r;
   logic                done_r;
   logic [BW-1:0]       bcd_r;
   logic [DIGITS-1:0]   blank_r;
   logic                ovf_r;

   logic [BW-1:0]       adj_s;
   logic [BW-1:0]       acc_next_s;
   logic [W-1:0]        bin_next_s;
   logic                ovf_in_s;

   // One double-dabble step: adjust digits, then shift {acc, bin} left by one.
   always_comb begin
      adj_s      = add3_all(acc_r);
      acc_next_s = {adj_s[BW-2:0], bin_r[W-1]};
      bin_next_s = {bin_r[W-2:0], 1'b0};
      ovf_in_s   = ({{(CMPW-W){1'b0}}, bin_in} > MAX_VAL);
   end

   // Control FSM with datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         bin_r      <= {W{1'b0}};
         acc_r      <= {BW{1'b0}};
         cnt_r      <= {CW{1'b0}};
         ovf_pend_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         bcd_r      <= {BW{1'b0}};
         blank_r    <= {DIGITS{1'b0}};
         ovf_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start_in) begin
                  bin_r      <= bin_in;
                  acc_r      <= {BW{1'b0}};
                  cnt_r      <= CW'(W);
                  ovf_pend_r <= ovf_in_s;
                  busy_r     <= 1'b1;
                  state_r    <= CONV;
               end else begin
                  state_r <= IDLE;
               end
            end
            CONV: begin
               acc_r <= acc_next_s;
               bin_r <= bin_next_s;
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == CW'(1)) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
                  ovf_r   <= ovf_pend_r;
                  if (ovf_pend_r) begin
                     bcd_r   <= {BW{1'b1}};
                     blank_r <= {DIGITS{1'b0}};
                  end else begin
                     bcd_r   <= acc_next_s;
                     blank_r <= leading_blank(acc_next_s);
                  end
               end else begin
                  state_r <= CONV;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy_out  = busy_r;
   assign done_out  = done_r;
   assign bcd_out   = bcd_r;
   assign blank_out = blank_r;
   assign ovf_out   = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, handshake/reset sequences
// and randomised values against a decimal-digit reference model.
module tb_bin2bcd_seq;

   localparam int W      = 20;
   localparam int DIGITS = 6;

   logic                clk;
   logic                rst;
   logic                start_in;
   logic [W-1:0]        bin_in;
   logic                busy_out;
   logic                done_out;
   logic [4*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]   blank_out;
   logic                ovf_out;

   int checks;
   int failures;

   bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_in (start_in),
      .bin_in   (bin_in),
      .busy_out (busy_out),
      .done_out (done_out),
      .bcd_out  (bcd_out),
      .blank_out(blank_out),
      .ovf_out  (ovf_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] bin;
      logic [23:0] bcd;
      logic [5:0]  blank;
      logic        ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Start a conversion and wait (bounded) for done; lat = edges after the start edge.
   task automatic convert(input logic [19:0] b, output int lat, output logic width_ok);
      lat      = 0;
      width_ok = 1'b0;
      @(negedge clk);
      start_in = 1'b1;
      bin_in   = b;
      @(posedge clk);
      @(negedge clk);
      start_in = 1'b0;
      bin_in   = 20'($urandom);
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) begin
            @(posedge clk);
            @(negedge clk);
         end
         bin_in = 20'($urandom);
         if (done_out === 1'b1) begin
            lat = k - 1;
            break;
         end
      end
      @(posedge clk);
      @(negedge clk);
      width_ok = (done_out === 1'b0);
   endtask

   task automatic model(input logic [19:0] b, output logic [23:0] bcd,
                        output logic [5:0] blank, output logic ovf);
      int v;
      logic za;
      v     = int'(b);
      blank = 6'b000000;
      if (v > 999999) begin
         ovf = 1'b1;
         bcd = 24'hFFFFFF;
      end else begin
         ovf = 1'b0;
         for (int i = 0; i < 6; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
         end
         za = 1'b1;
         for (int i = 5; i > 0; i--) begin
            za       = za & (bcd[4*i +: 4] == 4'd0);
            blank[i] = za;
         end
      end
   endtask

   initial begin
      int          lat;
      logic        wok;
      logic [23:0] ebcd;
      logic [5:0]  eblank;
      logic        eovf;
      logic [19:0] r;
      int          dones;
      int          done_at;
      int          busy_bad;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      start_in = 1'b0;
      bin_in   = 20'd0;

      vecs[0] = '{20'd0,       24'h000000, 6'b111110, 1'b0};
      vecs[1] = '{20'd123456,  24'h123456, 6'b000000, 1'b0};
      vecs[2] = '{20'd42,      24'h000042, 6'b111100, 1'b0};
      vecs[3] = '{20'd999999,  24'h999999, 6'b000000, 1'b0};
      vecs[4] = '{20'd1000000, 24'hFFFFFF, 6'b000000, 1'b1};
      vecs[5] = '{20'hFFFFF,   24'hFFFFFF, 6'b000000, 1'b1};
      vecs[6] = '{20'd65535,   24'h065535, 6'b100000, 1'b0};
      vecs[7] = '{20'd9,       24'h000009, 6'b111110, 1'b0};
      vecs[8] = '{20'd10,      24'h000010, 6'b111100, 1'b0};
      vecs[9] = '{20'd100000,  24'h100000, 6'b000000, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy",  32'(busy_out),  32'(0));
      chk("reset_done",  32'(done_out),  32'(0));
      chk("reset_bcd",   32'(bcd_out),   32'(0));
      chk("reset_blank", 32'(blank_out), 32'(0));
      chk("reset_ovf",   32'(ovf_out),   32'(0));
      rst = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         convert(vecs[i].bin, lat, wok);
         chk("vec_latency", 32'(lat),       32'(W));
         chk("vec_bcd",     32'(bcd_out),   32'(vecs[i].bcd));
         chk("vec_blank",   32'(blank_out), 32'(vecs[i].blank));
         chk("vec_ovf",     32'(ovf_out),   32'(vecs[i].ovf));
         chk("vec_done_w",  32'(wok),       32'(1));
         chk("vec_idle",    32'(busy_out),  32'(0));
      end

      // Starts during CONV and DONE are ignored
      @(negedge clk);
      start_in = 1'b1;
      bin_in   = 20'd7;
      @(posedge clk);
      dones    = 0;
      done_at  = -1;
      busy_bad = 0;
      for (int k = 0; k <= 40; k++) begin
         @(negedge clk);
         if (done_out === 1'b1) begin
            dones++;
            done_at = k;
         end
         if (k <= W && busy_out !== 1'b1) busy_bad++;
         if (k == W + 1 && busy_out !== 1'b0) busy_bad++;
         start_in = (k == 5 || k == W) ? 1'b1 : 1'b0;
         bin_in   = 20'd500;
      end
      chk("ign_dones",   32'(dones),    32'(1));
      chk("ign_done_at", 32'(done_at),  32'(W));
      chk("ign_busy",    32'(busy_bad), 32'(0));
      chk("ign_bcd",     32'(bcd_out),  32'(24'h000007));
      chk("ign_blank",   32'(blank_out), 32'(6'b111110));

      // Reset mid-conversion aborts
      @(negedge clk);
      start_in = 1'b1;
      bin_in   = 20'd65535;
      @(posedge clk);
      dones = 0;
      for (int k = 0; k <= 40; k++) begin
         @(negedge clk);
         if (done_out === 1'b1) dones++;
         start_in = 1'b0;
         rst      = (k == 10) ? 1'b1 : 1'b0;
      end
      chk("abort_dones", 32'(dones),     32'(0));
      chk("abort_busy",  32'(busy_out),  32'(0));
      chk("abort_bcd",   32'(bcd_out),   32'(0));
      chk("abort_blank", 32'(blank_out), 32'(0));
      chk("abort_ovf",   32'(ovf_out),   32'(0));
      convert(20'd65535, lat, wok);
      chk("restart_lat",   32'(lat),       32'(W));
      chk("restart_bcd",   32'(bcd_out),   32'(24'h065535));
      chk("restart_blank", 32'(blank_out), 32'(6'b100000));

      // Reset on the DONE edge wins
      @(negedge clk);
      start_in = 1'b1;
      bin_in   = 20'd321;
      @(posedge clk);
      dones = 0;
      for (int k = 0; k <= 30; k++) begin
         @(negedge clk);
         if (done_out === 1'b1) dones++;
         start_in = 1'b0;
         rst      = (k == W - 1) ? 1'b1 : 1'b0;
      end
      chk("rstdone_dones", 32'(dones),   32'(0));
      chk("rstdone_bcd",   32'(bcd_out), 32'(0));

      // Randomised values vs reference model
      for (int n = 0; n < 1000; n++) begin
         r = 20'($urandom_range(0, 20'hFFFFF));
         if (n == 0) r = 20'd999999;
         if (n == 1) r = 20'd1000000;
         model(r, ebcd, eblank, eovf);
         convert(r, lat, wok);
         chk("rnd_latency", 32'(lat),       32'(W));
         chk("rnd_bcd",     32'(bcd_out),   32'(ebcd));
         chk("rnd_blank",   32'(blank_out), 32'(eblank));
         chk("rnd_ovf",     32'(ovf_out),   32'(eovf));
         chk("rnd_done_w",  32'(wok),       32'(1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
